// File: rtl/pe_pkg.sv
// Shared PE constants, data types and the ofmap compressor state encoding.
package pe_pkg;
    localparam int ACC_BW  = 36;
    localparam int DATA_BW = 16;
    localparam int NUM_CH  = 32;
    localparam int NUM_ROW = 3;
    localparam int C_BW    = $clog2(NUM_CH);
    localparam int NUM_ENT = NUM_ROW * NUM_CH;
    localparam int IDX_BW  = $clog2(NUM_ENT);
    localparam int NNZ_BW  = IDX_BW + 1;

    typedef logic signed [ACC_BW-1:0]  acc_t;
    typedef logic signed [DATA_BW-1:0] data_t;
    typedef logic        [C_BW-1:0]    c_idx_t;

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} ofmap_state_e;
endpackage

// File: rtl/pe_requant.sv
// Requantizes one accumulator: arithmetic shift, saturate to DATA_BW, optional ReLU
// (ReLU enabled by defining PE_OFMAP_RELU_EN).
module pe_requant
    import pe_pkg::*;
(
    input  acc_t       i_acc,
    input  logic [4:0] i_shift,
    output data_t      o_q
);
    localparam acc_t SAT_MAX = acc_t'({(DATA_BW-1){1'b1}});
    localparam acc_t SAT_MIN = ~SAT_MAX;

    acc_t  w_sh;
    data_t w_sat;

    assign w_sh = i_acc >>> i_shift;

    always_comb begin
        w_sat = w_sh[DATA_BW-1:0];
        if (w_sh > SAT_MAX)
            w_sat = SAT_MAX[DATA_BW-1:0];
        else if (w_sh < SAT_MIN)
            w_sat = SAT_MIN[DATA_BW-1:0];
    end

`ifdef PE_OFMAP_RELU_EN
    assign o_q = w_sat[DATA_BW-1] ? '0 : w_sat;
`else
    assign o_q = w_sat;
`endif
endmodule

// File: rtl/pe_ofmap_compressor.sv
// Drains the PE output-feature accumulator buffer, requantizes, drops zeros and streams
// (data, channel, row) beats in index order. ReLU option: PE_OFMAP_RELU_EN.
module pe_ofmap_compressor
    import pe_pkg::*;
(
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_start,
    input  logic [NUM_ENT-1:0][ACC_BW-1:0]  i_acc_buf,
    input  logic [4:0]                      i_shift,
    output logic                            o_busy,
    output logic                            o_valid,
    input  logic                            i_ready,
    output data_t                           o_data,
    output c_idx_t                          o_c_idx,
    output logic [1:0]                      o_row,
    output logic                            o_last,
    output logic                            o_finish,
    output logic [NNZ_BW-1:0]               o_nnz
);
    ofmap_state_e                      r_state;
    logic [4:0]                        r_shift;
    logic [NUM_ENT-1:0]                r_mask;
    logic [IDX_BW-1:0]                 r_idx;
    logic [NNZ_BW-1:0]                 r_cnt;
    data_t                             r_data;
    logic                              r_valid;
    logic                              r_finish;

    logic [NUM_ENT-1:0][DATA_BW-1:0]   w_q_all;
    logic [NUM_ENT-1:0]                w_nz;
    logic [NUM_ENT-1:0]                w_cur_oh;
    logic [NUM_ENT-1:0]                w_mask_clr;
    logic [NUM_ENT-1:0]                w_mask_src;
    logic [IDX_BW-1:0]                 w_nxt_idx;
    data_t                             w_nxt_q;
    logic                              w_hs;

    // Full-tile requantization; only its nonzero-ness is kept in the mask.
    for (genvar g = 0; g < NUM_ENT; g++) begin : g_ent
        pe_requant u_rq (
            .i_acc   (acc_t'(i_acc_buf[g])),
            .i_shift (r_shift),
            .o_q     (w_q_all[g])
        );
        assign w_nz[g] = |w_q_all[g];
    end

    assign w_cur_oh   = {{(NUM_ENT-1){1'b0}}, 1'b1} << r_idx;
    assign w_mask_clr = r_mask & ~w_cur_oh;
    assign w_mask_src = (r_state == LOAD) ? w_nz : w_mask_clr;
    assign w_hs       = r_valid && i_ready;

    // Lowest set bit of the mask that will be live next cycle.
    always_comb begin
        w_nxt_idx = '0;
        for (int i = NUM_ENT - 1; i >= 0; i--)
            if (w_mask_src[i]) w_nxt_idx = IDX_BW'(i);
    end

    pe_requant u_rq_out (
        .i_acc   (acc_t'(i_acc_buf[w_nxt_idx])),
        .i_shift (r_shift),
        .o_q     (w_nxt_q)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_mask   <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_finish <= 1'b0;
        end else begin
            r_finish <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state <= LOAD;
                        r_shift <= i_shift;
                    end
                end
                LOAD: begin
                    r_mask <= w_nz;
                    r_cnt  <= '0;
                    if (w_nz == '0) begin
                        r_state  <= DONE;
                        r_finish <= 1'b1;
                    end else begin
                        r_state <= STREAM;
                        r_valid <= 1'b1;
                        r_data  <= w_nxt_q;
                        r_idx   <= w_nxt_idx;
                    end
                end
                STREAM: begin
                    if (w_hs) begin
                        r_mask <= w_mask_clr;
                        r_cnt  <= r_cnt + NNZ_BW'(1);
                        if (w_mask_clr == '0) begin
                            r_state  <= DONE;
                            r_valid  <= 1'b0;
                            r_finish <= 1'b1;
                        end else begin
                            r_data <= w_nxt_q;
                            r_idx  <= w_nxt_idx;
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Busy rises in the accepting cycle itself and drops as o_finish pulses.
    assign o_busy   = (r_state == LOAD) || (r_state == STREAM) || ((r_state == IDLE) && i_start);
    assign o_valid  = r_valid;
    assign o_data   = r_data;
    assign o_c_idx  = r_idx[C_BW-1:0];
    assign o_row    = r_idx[IDX_BW-1:C_BW];
    assign o_last   = r_valid && (w_mask_clr == '0);
    assign o_finish = r_finish;
    assign o_nnz    = r_cnt;
endmodule
